cory_sd2b_arb: RTL and testbench
================================

# cory_sd2b_arb

Round-robin scheduler that shares one start/done-style resource, such as a block guarded by a busy flag, among N requesters. It collects level requests, grants one requester at a time, and issues a single-cycle start pulse to the resource. It then waits for the resource's done pulse and routes a completion pulse back to the granted requester. It sits between client engines and a single shared sequential unit.

## Interface
- N, 4, number of requesters (2..16)
- GW, 2, grant-index width; must equal clog2(N)
- TW, 8, timeout counter width (used only with the timeout feature)

- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- i_req  input  N  per-requester request level; held until the matching o_ack
- o_ack  output  N  one-hot, one-cycle pulse: request accepted and resource started
- o_done  output  N  one-hot, one-cycle pulse: granted job finished
- o_start  output  1  one-cycle start pulse to the shared resource
- i_done  input  1  done pulse from the shared resource
- o_busy  output  1  high while a job is granted (states START and WAIT)
- o_gnt_id  output  GW  index of the current/last granted requester
- o_timeout  output  1  one-cycle pulse on watchdog abort

## Operation
- FSM states: IDLE, START, WAIT.
- IDLE
  - If i_req is non-zero, select the first set bit searching upward from (ptr+1) mod N, wrapping around.
  - Register the selection into gnt and o_gnt_id, then go to START.
  - With no request, stay in IDLE.
- START
  - o_start=1 and o_ack[gnt]=1 for exactly this cycle; then go to WAIT.
  - The grant is committed even if i_req[gnt] drops during START.
- WAIT
  - On i_done=1: go to IDLE, pulse o_done[gnt] in the first IDLE cycle (registered), and set ptr<=gnt.
- i_done is sampled only in WAIT; it is ignored in IDLE and START.
- A request bit that drops while in IDLE, before selection, is simply not granted; no error.
- Output decoding:
  - o_start, o_ack and o_busy are decoded from the state register only; no combinational path from the inputs.
  - o_done and o_timeout are registered.
- Reset values:
  - state=IDLE; ptr=N-1, so requester 0 has first priority.
  - o_ack=0, o_done=0, o_start=0, o_busy=0, o_gnt_id=0, o_timeout=0; timeout counter=0.
- Reset mid-operation: all of the above apply immediately (asynchronous). No o_done is issued for the aborted job, and the resource is not notified.

## Timing
- A request sampled in IDLE at edge T gives o_start and o_ack at cycle T+1 and o_busy=1 from T+1.
- i_done sampled in WAIT at edge D gives o_done at D+1, with o_busy=0 at D+1.
- If a request is pending at D+1, the next o_start is at D+2. Minimum job-to-job spacing is 3 cycles (IDLE, START, WAIT with immediate done).
- Fairness: with all N requests held high, grants rotate 0,1,…,N-1,0, and no requester waits more than N-1 jobs.

## Configuration
- CORY_SD2B_ARB_TIMEOUT_EN defined:
  - A TW-bit counter clears on entry to WAIT and increments each WAIT cycle without i_done.
  - When it reaches 2^TW-1 with no i_done: go to IDLE, and pulse o_timeout and o_done[gnt] together at the next cycle. ptr updates as on a normal done.
  - If i_done arrives on the same cycle the counter reaches 2^TW-1, it is a normal done and o_timeout=0.
- Not defined: no counter is built, o_timeout is tied to 0, WAIT waits indefinitely, and TW is unused.

## Test plan
- Single request: i_req=4'b0100 from idle after reset → o_start and o_ack=4'b0100 one cycle later; i_done 5 cycles after that → o_done=4'b0100 next cycle; o_gnt_id=2 throughout.
- Round-robin: i_req=4'b1111 held with i_done 2 cycles after each start → grant order 0,1,2,3,0,1; each o_ack one-hot.
- Wrap and skip: ptr=3 and i_req=4'b0101 → grant 0, then 2, then 0.
- Ignored done: i_done pulsed during IDLE and during START → no o_done and no state change; the job finishes only on an i_done in WAIT.
- Reset in WAIT: assert reset_n=0 two cycles after o_start → all outputs 0 immediately, no o_done; after release, i_req=4'b0010 is granted with ptr reset (requester 0 would win a tie).
- Timeout (macro on, TW=4): no i_done after start → o_timeout and o_done[gnt] pulse 16 cycles after WAIT entry (15 counted cycles plus the registered pulse), then idle. With the macro off → busy held indefinitely and o_timeout=0.

Source files
------------

// File: rtl/cory_sd2b_arb.sv
// cory_sd2b_arb: round-robin scheduler sharing one start/done resource among N requesters.
// Optional watchdog abort in WAIT is built when CORY_SD2B_ARB_TIMEOUT_EN is defined.
module cory_sd2b_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned GW = 2,
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_ack,
    output logic [N-1:0]  o_done,
    output logic          o_start,
    input  logic          i_done,
    output logic          o_busy,
    output logic [GW-1:0] o_gnt_id,
    output logic          o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    if (N < 2 || N > 16 || GW != $clog2(N) || TW < 1) begin : g_bad_param
        $error("cory_sd2b_arb: illegal parameter combination");
    end

    state_t        state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [N-1:0]  done_q, done_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          tmo_q, tmo_d;
    logic [GW-1:0] cand_c;
    logic [GW-1:0] sel_c;
    logic          sel_vld_c;
    logic          tmo_hit_c;

    function automatic logic [N-1:0] one_hot(input logic [GW-1:0] idx);
        return N'(1) << idx;
    endfunction

    // First requesting index searching upward from ptr+1, wrapping at N.
    always_comb begin
        sel_vld_c = 1'b0;
        sel_c     = '0;
        cand_c    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand_c = GW'((32'(ptr_q) + 32'd1 + i) % N);
            if (!sel_vld_c && i_req[cand_c]) begin
                sel_vld_c = 1'b1;
                sel_c     = cand_c;
            end
        end
    end

`ifdef CORY_SD2B_ARB_TIMEOUT_EN
    logic [TW-1:0] cnt_q, cnt_d;

    assign tmo_hit_c = (state_q == S_WAIT) && !i_done && (cnt_q == {TW{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT && !i_done && !tmo_hit_c) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Next state; pulse outputs are registered from the next state so they track the state register.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_vld_c) begin
                    gnt_d   = sel_c;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_done || tmo_hit_c) begin
                    state_d = S_IDLE;
                    ptr_d   = gnt_q;
                    done_d  = one_hot(gnt_q);
                    tmo_d   = tmo_hit_c;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        start_d = (state_d == S_START);
        ack_d   = start_d ? one_hot(gnt_d) : '0;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= GW'(N - 1);
            gnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_ack     = ack_q;
    assign o_done    = done_q;
    assign o_start   = start_q;
    assign o_busy    = busy_q;
    assign o_gnt_id  = gnt_q;
    assign o_timeout = tmo_q;

endmodule

// File: tb/tb_cory_sd2b_arb.sv
// Self-checking bench for cory_sd2b_arb: vector table, directed corner sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_cory_sd2b_arb;

    localparam int N  = 4;
    localparam int GW = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  i_req;
    logic          i_done;
    logic [N-1:0]  o_ack;
    logic [N-1:0]  o_done;
    logic          o_start;
    logic          o_busy;
    logic [GW-1:0] o_gnt_id;
    logic          o_timeout;

    int checks = 0;
    int errors = 0;

    cory_sd2b_arb #(.N(N), .GW(GW), .TW(TW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .o_ack     (o_ack),
        .o_done    (o_done),
        .o_start   (o_start),
        .i_done    (i_done),
        .o_busy    (o_busy),
        .o_gnt_id  (o_gnt_id),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] exp_ack;
        logic       exp_start;
        logic       exp_busy;
        logic [3:0] exp_done;
        logic [1:0] exp_gnt;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_req   = '0;
        i_done  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ack"},   32'(o_ack),     32'd0);
        chk({tag, ".done"},  32'(o_done),    32'd0);
        chk({tag, ".start"}, 32'(o_start),   32'd0);
        chk({tag, ".busy"},  32'(o_busy),    32'd0);
        chk({tag, ".gnt"},   32'(o_gnt_id),  32'd0);
        chk({tag, ".tmo"},   32'(o_timeout), 32'd0);
    endtask

    // One full job: wait (bounded) for the start, check the grant, finish it 2 cycles later.
    task automatic do_job(input logic [3:0] req, input int exp_id, input string tag);
        int n;
        logic [3:0] exp_oh;
        exp_oh = 4'(1 << exp_id);
        i_req  = req;
        i_done = 1'b0;
        n = 0;
        while (o_start !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        if (n >= 10) begin
            chk({tag, ".start_seen"}, 32'(o_start), 32'd1);
        end else begin
            chk({tag, ".ack"}, 32'(o_ack), 32'(exp_oh));
            chk({tag, ".ack_onehot"}, 32'($countones(o_ack)), 32'd1);
            chk({tag, ".gnt"}, 32'(o_gnt_id), 32'(exp_id));
            step();
            i_done = 1'b1;
            step();
            i_done = 1'b0;
            chk({tag, ".done"}, 32'(o_done), 32'(exp_oh));
            chk({tag, ".busy"}, 32'(o_busy), 32'd0);
        end
    endtask

    // Round-robin winner: smallest rotational distance past the last served index.
    function automatic int pick(input logic [3:0] req, input int last);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                d = (i - last - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    initial begin
        // reset-in-sequence vector table, starting from ptr = N-1
        tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2};
        tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2};
        tbl[5]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 2'd0};
        tbl[6]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0};
        tbl[7]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0};
        tbl[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2};
        tbl[9]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2};
        tbl[10] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2};
        tbl[11] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 2'd0};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0};
        tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0};

        // reset values
        do_reset();
        chk_all_zero("reset");

        // single request, done 5 cycles after start
        i_req = 4'b0100;
        step();
        chk("single.start", 32'(o_start), 32'd1);
        chk("single.ack", 32'(o_ack), 32'h4);
        chk("single.gnt", 32'(o_gnt_id), 32'd2);
        i_req = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("single.wait_busy", 32'(o_busy), 32'd1);
            chk("single.wait_done", 32'(o_done), 32'd0);
            chk("single.wait_gnt", 32'(o_gnt_id), 32'd2);
        end
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        chk("single.done", 32'(o_done), 32'h4);
        chk("single.busy_off", 32'(o_busy), 32'd0);
        chk("single.gnt_hold", 32'(o_gnt_id), 32'd2);
        step();
        chk("single.done_pulse", 32'(o_done), 32'd0);

        // vector table: ignored done in IDLE/START, wrap and skip
        do_reset();
        for (int k = 0; k < 15; k++) begin
            i_req  = tbl[k].req;
            i_done = tbl[k].done;
            step();
            chk($sformatf("tbl%0d.ack", k),   32'(o_ack),     32'(tbl[k].exp_ack));
            chk($sformatf("tbl%0d.start", k), 32'(o_start),   32'(tbl[k].exp_start));
            chk($sformatf("tbl%0d.busy", k),  32'(o_busy),    32'(tbl[k].exp_busy));
            chk($sformatf("tbl%0d.done", k),  32'(o_done),    32'(tbl[k].exp_done));
            chk($sformatf("tbl%0d.gnt", k),   32'(o_gnt_id),  32'(tbl[k].exp_gnt));
            chk($sformatf("tbl%0d.tmo", k),   32'(o_timeout), 32'd0);
        end

        // round-robin with all requests held
        do_reset();
        for (int k = 0; k < 6; k++) do_job(4'b1111, k % N, $sformatf("rr%0d", k));

        // wrap and skip from ptr = 3
        do_reset();
        do_job(4'b0101, 0, "skip0");
        do_job(4'b0101, 2, "skip1");
        do_job(4'b0101, 0, "skip2");

        // reset in WAIT
        do_reset();
        i_req = 4'b0100;
        step();
        chk("rstwait.start", 32'(o_start), 32'd1);
        i_req = '0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("rstwait.async");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rstwait.no_done", 32'(o_done), 32'd0);
            chk("rstwait.idle", 32'(o_busy), 32'd0);
        end
        i_req = 4'b0010;
        step();
        chk("rstwait.regrant_ack", 32'(o_ack), 32'h2);
        chk("rstwait.regrant_gnt", 32'(o_gnt_id), 32'd1);
        i_req = '0;
        step();
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        do_reset();
        i_req = 4'b0011;
        step();
        chk("tie.ack", 32'(o_ack), 32'h1);
        i_req = '0;
        step();
        i_done = 1'b1;
        step();
        i_done = 1'b0;

        // watchdog
        do_reset();
        i_req = 4'b0001;
        step();
        chk("tmo.start", 32'(o_start), 32'd1);
        i_req = '0;
`ifdef CORY_SD2B_ARB_TIMEOUT_EN
        begin
            int seen;
            seen = -1;
            for (int c = 1; c <= 40 && seen < 0; c++) begin
                step();
                if (o_timeout === 1'b1) begin
                    seen = c;
                    chk("tmo.done", 32'(o_done), 32'h1);
                    chk("tmo.busy", 32'(o_busy), 32'd0);
                end
            end
            chk("tmo.latency", 32'(seen), 32'd17);
            step();
            chk("tmo.pulse", 32'(o_timeout), 32'd0);
            chk("tmo.idle", 32'(o_busy), 32'd0);
        end
`else
        for (int c = 0; c < 40; c++) begin
            step();
            chk("notmo.busy", 32'(o_busy), 32'd1);
            chk("notmo.tmo", 32'(o_timeout), 32'd0);
        end
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        chk("notmo.done", 32'(o_done), 32'h1);
`endif

        // randomized traffic against the model
        do_reset();
        begin
            logic [3:0] hold;
            logic [3:0] cur_req;
            logic [3:0] exp_ack;
            logic [3:0] exp_done;
            logic       cur_done;
            logic       drv_done;
            logic       exp_start;
            bit         job;
            int         age;
            int         owner;
            int         last;
            int         shown;
            int         dly;
            hold     = '0;
            drv_done = 1'b0;
            job      = 0;
            age      = 0;
            owner    = 0;
            last     = N - 1;
            shown    = 0;
            dly      = 0;
            for (int c = 0; c < 2000; c++) begin
                cur_req  = hold;
                cur_done = drv_done;
                i_req    = cur_req;
                i_done   = cur_done;
                step();
                exp_ack   = '0;
                exp_done  = '0;
                exp_start = 1'b0;
                if (!job) begin
                    if (cur_req != '0) begin
                        owner     = pick(cur_req, last);
                        shown     = owner;
                        job       = 1;
                        age       = 0;
                        exp_ack   = 4'(1 << owner);
                        exp_start = 1'b1;
                    end
                end else if (age == 0) begin
                    age = 1;
                end else if (cur_done) begin
                    job      = 0;
                    exp_done = 4'(1 << owner);
                    last     = owner;
                end else begin
                    age++;
                end
                chk("rnd.ack",   32'(o_ack),     32'(exp_ack));
                chk("rnd.start", 32'(o_start),   32'(exp_start));
                chk("rnd.busy",  32'(o_busy),    32'(job));
                chk("rnd.done",  32'(o_done),    32'(exp_done));
                chk("rnd.gnt",   32'(o_gnt_id),  32'(shown));
                chk("rnd.tmo",   32'(o_timeout), 32'd0);
                for (int i = 0; i < N; i++) begin
                    if (exp_ack[i]) hold[i] = 1'b0;
                    else if (!hold[i] && ($urandom % 3) == 0) hold[i] = 1'b1;
                    else if (hold[i] && !job && ($urandom % 10) == 0) hold[i] = 1'b0;
                end
                if (job && age == 0) begin
                    dly      = int'($urandom % 6);
                    drv_done = (($urandom % 2) == 0);
                end else if (job) begin
                    drv_done = (dly == 0);
                    if (dly > 0) dly--;
                end else begin
                    drv_done = (($urandom % 5) == 0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
